// File: rtl/dmem_waitstate.sv
// dmem_waitstate: word-addressed data memory for the M stage with programmable wait states,
// misalignment detection and a saturating stall-cycle counter.
module dmem_waitstate #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memreadM,
   input  logic        memwriteM,
   input  logic [31:0] addrM,
   input  logic [31:0] writedataM,
   output logic [31:0] readdataM,
   output logic        stallM,
   output logic        errM,
   output logic [31:0] stallcnt
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(WAIT_STATES);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic            r_live;
   logic [31:0]     r_mem [DEPTH_WORDS];
   logic            w_req, w_aligned, w_resp, w_we;
   logic [AW-1:0]   w_idx;
   assign w_req     = memreadM | memwriteM;
   assign w_aligned = addrM[1:0] == 2'b00;
   assign w_idx     = addrM[AW+1:2];
   assign w_we      = w_resp & memwriteM;
   assign readdataM = (w_resp && memreadM) ? r_mem[w_idx] : '0;
   // r_live drops asynchronously with reset so every combinational output is quiet during reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_live  <= 1'b0;
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_live  <= 1'b1;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end
   always_comb begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      stallM      = 1'b0;
      errM        = 1'b0;
      w_resp      = 1'b0;
      if (r_live) begin
         case (r_state)
            IDLE: begin
               if (w_req && !w_aligned) begin
                  errM = 1'b1;
               end else if (w_req && WAIT_STATES == 0) begin
                  w_resp = 1'b1;
               end else if (w_req) begin
                  stallM      = 1'b1;
                  w_cnt_nxt   = CW'(1);
                  w_state_nxt = (LAST == CW'(1)) ? RESP : WAIT;
               end
            end
            WAIT: begin
               stallM      = 1'b1;
               w_cnt_nxt   = r_cnt + 1'b1;
               w_state_nxt = !w_req ? IDLE : (w_cnt_nxt == LAST) ? RESP : WAIT;
            end
            RESP: w_resp = 1'b1;
            default: w_state_nxt = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_idx] <= writedataM;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) stallcnt <= '0;
      else if (stallM && !(&stallcnt)) stallcnt <= stallcnt + 32'd1;
   end
endmodule

// File: tb/tb_dmem_waitstate.sv
// tb_dmem_waitstate: randomized scoreboard bench for dmem_waitstate (WAIT_STATES=2 and 0).
module tb_dmem_waitstate;
   localparam int WS = 2;
   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      logic [31:0] scnt;
   } exp_t;
   logic        clk = 1'b0, reset = 1'b1;
   logic        memreadM = 0, memwriteM = 0;
   logic [31:0] addrM = 0, writedataM = 0, readdataM, stallcnt;
   logic        stallM, errM;
   logic        rd0 = 0, wr0 = 0;
   logic [31:0] a0 = 0, d0 = 0, rdata0, scnt0;
   logic        stall0, err0;
   int          checks = 0, failures = 0, run = 0;
   exp_t        q[$];
   logic [31:0] m[256], m0[256];
   bit          v[256], v0[256];
   logic [31:0] scnt_m = 0;

   dmem_waitstate #(.DEPTH_WORDS(256), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset(reset), .memreadM(memreadM), .memwriteM(memwriteM), .addrM(addrM),
      .writedataM(writedataM), .readdataM(readdataM), .stallM(stallM), .errM(errM), .stallcnt(stallcnt));
   dmem_waitstate #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset), .memreadM(rd0), .memwriteM(wr0), .addrM(a0),
      .writedataM(d0), .readdataM(rdata0), .stallM(stall0), .errM(err0), .stallcnt(scnt0));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // monitor: pops one expectation whenever a request is present and the DUT is not stalling
   always @(negedge clk) begin
      if (reset) run = 0;
      else if (memreadM || memwriteM) begin
         if (stallM) run++;
         else if (q.size() == 0) begin
            chk("unexpected_response", 32'd1, 32'd0);
            run = 0;
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("errM", {31'd0, errM}, {31'd0, e.err});
            chk("readdataM", readdataM, e.rdata);
            chk("stall_cycles", 32'(run), 32'(e.lat));
            chk("stallcnt", stallcnt, e.scnt);
            run = 0;
         end
      end else begin
         chk("idle_readdata", readdataM, 32'd0);
         chk("idle_err", {31'd0, errM}, 32'd0);
         run = 0;
      end
   end

   function automatic logic [31:0] rand_addr(input bit mis);
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
      if (mis) a = a | 32'($urandom_range(1, 3));
      return a;
   endfunction

   // called at posedge+1; returns at posedge+1 of the cycle after the response
   task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      int   idx;
      idx = int'(a[9:2]);
      if (a[1:0] != 2'b00) e = '{1'b1, 32'd0, 0, scnt_m};
      else begin
         scnt_m = scnt_m + WS;
         e = '{1'b0, rd ? m[idx] : 32'd0, WS, scnt_m};
         if (wr) begin
            m[idx] = d;
            v[idx] = 1'b1;
         end
      end
      q.push_back(e);
      memreadM = rd; memwriteM = wr; addrM = a; writedataM = d;
      for (int n = 0; ; n++) begin
         @(negedge clk);
         if (!stallM) break;
         if (n > 20) begin
            chk("access_timeout", 32'd1, 32'd0);
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      memreadM = 0; memwriteM = 0;
   endtask

   task automatic rand_access(input bit mis);
      logic [31:0] a;
      logic rd, wr;
      int op;
      a = rand_addr(mis);
      op = $urandom_range(0, 2);
      rd = op != 1; wr = op != 0;
      if (!v[a[9:2]]) begin rd = 0; wr = 1; end
      access(rd, wr, a, $urandom);
   endtask

   initial begin
      #1;
      chk("rst_stallM", {31'd0, stallM}, 32'd0);
      chk("rst_errM", {31'd0, errM}, 32'd0);
      chk("rst_readdata", readdataM, 32'd0);
      chk("rst_stallcnt", stallcnt, 32'd0);
      @(posedge clk); @(posedge clk); #3 reset = 0;
      @(posedge clk); #1;
      // basic store/load with two wait states
      access(0, 1, 32'h10, 32'hDEADBEEF);
      access(1, 0, 32'h10, 32'h0);
      chk("stallcnt_after_two", stallcnt, 32'd4);
      // misaligned load
      access(1, 0, 32'h13, 32'h0);
      access(1, 0, 32'h10, 32'h0);
      // dropped store: request removed during the wait state
      access(0, 1, 32'h40, 32'h01020304);
      memwriteM = 1; addrM = 32'h40; writedataM = 32'hBAD0BAD0;
      @(posedge clk); #1;
      memwriteM = 0;
      @(posedge clk); #1;
      chk("drop_idle_stall", {31'd0, stallM}, 32'd0);
      scnt_m = scnt_m + 2;
      access(1, 0, 32'h40, 32'h0);
      // wrap and simultaneous read/write
      access(0, 1, 32'h400, 32'hCAFEF00D);
      access(1, 0, 32'h0, 32'h0);
      access(1, 1, 32'h0, 32'h11112222);
      access(1, 0, 32'h400, 32'h0);
      // async reset mid-wait of a store
      access(0, 1, 32'h80, 32'h55555555);
      memwriteM = 1; addrM = 32'h80; writedataM = 32'h12345678;
      @(posedge clk); #3;
      reset = 1;
      #1;
      chk("midrst_stallM", {31'd0, stallM}, 32'd0);
      chk("midrst_errM", {31'd0, errM}, 32'd0);
      chk("midrst_stallcnt", stallcnt, 32'd0);
      memwriteM = 0;
      scnt_m = 0;
      @(posedge clk); @(posedge clk); #3 reset = 0;
      @(posedge clk); #1;
      access(1, 0, 32'h80, 32'h0);
      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         rand_access($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
      // zero wait-state instance: back-to-back, never stalls
      for (int i = 0; i < 32; i++) begin
         logic [31:0] a, er;
         bit mis;
         int op, idx;
         mis = (i > 1) && ($urandom_range(0, 7) == 0);
         a = (i < 2) ? 32'h20 : rand_addr(mis);
         idx = int'(a[9:2]);
         op = (i == 0) ? 1 : (i == 1) ? 0 : $urandom_range(0, 2);
         rd0 = op != 1; wr0 = op != 0;
         if (!v0[idx] && !mis) begin rd0 = 0; wr0 = 1; end
         a0 = a; d0 = (i == 0) ? 32'hA5A5_5A5A : $urandom;
         er = (rd0 && !mis) ? m0[idx] : 32'd0;
         @(negedge clk);
         chk("ws0_stallM", {31'd0, stall0}, 32'd0);
         chk("ws0_errM", {31'd0, err0}, {31'd0, mis});
         chk("ws0_readdata", rdata0, er);
         chk("ws0_stallcnt", scnt0, 32'd0);
         if (wr0 && !mis) begin m0[idx] = d0; v0[idx] = 1'b1; end
         @(posedge clk); #1;
      end
      rd0 = 0; wr0 = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
